// File: rtl/effective_address_unit.sv
// -----------------------------------------------------------------------------
// effective_address_unit
//
// Resolves the PDP-8 memory-reference effective address (EA) for one
// instruction. It sits directly upstream of memory_controller: the pointer
// read and the auto-index write-back are issued through the controller's
// address / enable / data ports.
//
// Addressing handled:
//   - direct, page zero      : EA = {5'b0, IR[6:0]}
//   - direct, current page   : EA = {pc[11:7], IR[6:0]}
//   - indirect               : EA = M[DA]
//   - auto-index (DA in AUTOINDEX_LO..AUTOINDEX_HI, indirect only):
//                              M[DA] <= M[DA] + 1, EA = M[DA] + 1
//   Opcodes 6 (IOT) and 7 (OPR) are not memory references; they complete
//   immediately with is_mem_ref = 0 and never touch memory.
//
// Parameters:
//   READ_LATENCY  cycles between the read-strobe cycle and the edge that
//                 samples mem_read_data (0 = combinational memory)
//   AUTOINDEX_LO  lowest auto-index location
//   AUTOINDEX_HI  highest auto-index location
//   DATA_READ     encoding of a data read on mem_read_type
//
// Ports:
//   clk               system clock, all state on the rising edge
//   reset_n           asynchronous, active-low reset
//   start             request EA resolution; sampled only in IDLE
//   instruction[11:0] IR[11:9] opcode, IR[8] I, IR[7] Z, IR[6:0] offset
//   pc[11:0]          address of the instruction (not incremented)
//   mem_read_data     read data from memory_controller
//   mem_address       address to memory_controller (0 when no strobe)
//   mem_write_data    write data to memory_controller (0 when no strobe)
//   mem_read_enable   one-cycle read strobe
//   mem_read_type     DATA_READ while mem_read_enable = 1, else 0
//   mem_write_enable  one-cycle write strobe
//   eaddr             resolved EA; held until the next accepted start
//   is_mem_ref        opcode 0-5; valid with eaddr
//   autoindexed       the auto-index increment was performed; valid with eaddr
//   busy              1 in every state except IDLE
//   done              one-cycle pulse: eaddr / is_mem_ref / autoindexed valid
//
// Latency, counting the start edge as cycle 0, done is high in:
//   cycle 1                   direct or non-memory-reference
//   cycle 2 + READ_LATENCY    indirect
//   cycle 3 + READ_LATENCY    auto-index
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module effective_address_unit #(
  parameter int unsigned READ_LATENCY = 0,
  parameter logic [11:0] AUTOINDEX_LO = 12'o0010,
  parameter logic [11:0] AUTOINDEX_HI = 12'o0017,
  parameter logic        DATA_READ    = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] instruction,
  input  logic [11:0] pc,
  input  logic [11:0] mem_read_data,
  output logic [11:0] mem_address,
  output logic [11:0] mem_write_data,
  output logic        mem_read_enable,
  output logic        mem_read_type,
  output logic        mem_write_enable,
  output logic [11:0] eaddr,
  output logic        is_mem_ref,
  output logic        autoindexed,
  output logic        busy,
  output logic        done
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE
  } state_e;

  // The wait counter is loaded with READ_LATENCY-1 and counts down to 0, so
  // it only has to hold READ_LATENCY-1. Keep at least one bit so the
  // declaration stays legal when READ_LATENCY is 0 or 1.
  localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Direct address: Z selects the current page of the instruction, otherwise
  // page zero.
  function automatic logic [11:0] direct_addr(input logic [11:0] ir,
                                              input logic [11:0] page_pc);
    return ir[7] ? {page_pc[11:7], ir[6:0]} : {5'b0, ir[6:0]};
  endfunction

  function automatic logic in_autoindex(input logic [11:0] addr);
    return (addr >= AUTOINDEX_LO) && (addr <= AUTOINDEX_HI);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q;
  logic [11:0]        da_q;        // direct address of the accepted instruction
  logic [11:0]        ptr_inc_q;   // incremented pointer awaiting write-back
  logic [CNT_W-1:0]   wait_cnt_q;

  logic [11:0]        mem_address_q;
  logic [11:0]        mem_write_data_q;
  logic               mem_read_enable_q;
  logic               mem_read_type_q;
  logic               mem_write_enable_q;
  logic [11:0]        eaddr_q;
  logic               is_mem_ref_q;
  logic               autoindexed_q;
  logic               busy_q;
  logic               done_q;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction and the read path
  // ---------------------------------------------------------------------------
  logic [11:0] da_d;          // direct address of the instruction on the inputs
  logic        mem_ref_d;     // opcode 0-5
  logic        indirect_d;    // needs the pointer read
  logic        sample_d;      // this edge samples mem_read_data
  logic [11:0] ptr_inc_d;     // sampled pointer + 1, wraps 7777 -> 0000

  // NOTE: every signal assigned in always_comb gets a default at the top, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    da_d       = direct_addr(instruction, pc);
    mem_ref_d  = (instruction[11:9] < 3'd6);
    indirect_d = mem_ref_d && instruction[8];
    sample_d   = 1'b0;
    if (state_q == S_RD) begin
      sample_d = (READ_LATENCY == 0);
    end else if (state_q == S_WAIT) begin
      sample_d = (wait_cnt_q == '0);
    end
    ptr_inc_d  = mem_read_data + 12'd1;
  end

  // pc[6:0] never matters: the page of the instruction is pc[11:7] and the
  // offset always comes from IR[6:0].
  logic unused_pc_offset;
  assign unused_pc_offset = ^pc[6:0];

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  //
  // Strobes and done are one-cycle events: they default low on every edge and
  // the transition into the state that owns them raises them for exactly that
  // state's single cycle. mem_address / mem_write_data fall back to 0 with the
  // strobes.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: every register, including the latched address and the wait
    // counter, is cleared by reset; a reset mid-transaction therefore drops
    // any active strobe immediately and leaves no stale transaction behind.
    if (!reset_n) begin
      state_q            <= S_IDLE;
      da_q               <= '0;
      ptr_inc_q          <= '0;
      wait_cnt_q         <= '0;
      mem_address_q      <= '0;
      mem_write_data_q   <= '0;
      mem_read_enable_q  <= 1'b0;
      mem_read_type_q    <= 1'b0;
      mem_write_enable_q <= 1'b0;
      eaddr_q            <= '0;
      is_mem_ref_q       <= 1'b0;
      autoindexed_q      <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
    end else begin
      mem_address_q      <= '0;
      mem_write_data_q   <= '0;
      mem_read_enable_q  <= 1'b0;
      mem_read_type_q    <= 1'b0;
      mem_write_enable_q <= 1'b0;
      done_q             <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            da_q          <= da_d;
            is_mem_ref_q  <= mem_ref_d;
            autoindexed_q <= 1'b0;
            busy_q        <= 1'b1;
            if (indirect_d) begin
              // Pointer read is issued in the RD cycle that follows.
              state_q           <= S_RD;
              mem_read_enable_q <= 1'b1;
              mem_read_type_q   <= DATA_READ;
              mem_address_q     <= da_d;
            end else begin
              // Direct reference or IOT/OPR: the EA is the direct address.
              state_q <= S_DONE;
              eaddr_q <= da_d;
              done_q  <= 1'b1;
            end
          end
        end

        S_RD, S_WAIT: begin
          if (sample_d) begin
            // The range test uses DA, so a current-page reference on page 0
            // that lands on an auto-index location also increments.
            if (in_autoindex(da_q)) begin
              state_q            <= S_WR;
              ptr_inc_q          <= ptr_inc_d;
              mem_write_enable_q <= 1'b1;
              mem_address_q      <= da_q;
              mem_write_data_q   <= ptr_inc_d;
            end else begin
              state_q <= S_DONE;
              eaddr_q <= mem_read_data;
              done_q  <= 1'b1;
            end
          end else if (state_q == S_RD) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= CNT_LOAD;
          end else begin
            wait_cnt_q <= wait_cnt_q - CNT_W'(1);
          end
        end

        S_WR: begin
          state_q       <= S_DONE;
          eaddr_q       <= ptr_inc_q;
          autoindexed_q <= 1'b1;
          done_q        <= 1'b1;
        end

        S_DONE: begin
          // A start seen here is dropped, not queued.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_address      = mem_address_q;
  assign mem_write_data   = mem_write_data_q;
  assign mem_read_enable  = mem_read_enable_q;
  assign mem_read_type    = mem_read_type_q;
  assign mem_write_enable = mem_write_enable_q;
  assign eaddr            = eaddr_q;
  assign is_mem_ref       = is_mem_ref_q;
  assign autoindexed      = autoindexed_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
